// File: rtl/nor_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined reduction tree.
// The helpers size the tree levels and place each level's vector on one flat bus.
package nor_reduce_pkg;

  localparam logic [1:0] MODE_NOR  = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_NAND = 2'd2;
  localparam logic [1:0] MODE_AND  = 2'd3;

  // Number of FANIN-input levels needed to bring width down to one bit (at least 1).
  function automatic int clog_fanin(input int width, input int fanin);
    int w;
    int lv;
    w  = width;
    lv = 0;
    while (w > 1) begin
      w  = (w + fanin - 1) / fanin;
      lv = lv + 1;
    end
    return (lv < 1) ? 1 : lv;
  endfunction

  // Vector width entering level k (k = LEVELS gives the final 1-bit width).
  function automatic int level_width(input int width, input int fanin, input int k);
    int w;
    w = width;
    for (int i = 0; i < k; i++) w = (w + fanin - 1) / fanin;
    return w;
  endfunction

  function automatic int level_offset(input int width, input int fanin, input int k);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) off = off + level_width(width, fanin, i);
    return off;
  endfunction

  function automatic logic invert_result(input logic [1:0] m);
    return (m == MODE_NOR) || (m == MODE_NAND);
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One tree level: FANIN-wide group reduce with identity padding, then the stage register.
// The stage loads whenever adv is high; data/mode only change when a real beat arrives.
module reduce_stage
  import nor_reduce_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int FANIN = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                adv,
  input  logic                                up_valid,
  input  logic [1:0]                          up_mode,
  input  logic [IN_W-1:0]                     up_data,
  output logic                                valid_q,
  output logic [1:0]                          mode_q,
  output logic [(IN_W+FANIN-1)/FANIN-1:0]     data_q
);

  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;
  localparam int PAD_W = OUT_W * FANIN;

  logic [PAD_W-1:0] padded;
  logic [OUT_W-1:0] red;

  // mode[1] selects the AND class; its identity (1) fills the pad leaves, OR class pads with 0.
  always_comb begin
    padded            = {PAD_W{up_mode[1]}};
    padded[IN_W-1:0]  = up_data;
    red               = '0;
    for (int g = 0; g < OUT_W; g++) begin
      red[g] = up_mode[1] ? (&padded[g*FANIN +: FANIN]) : (|padded[g*FANIN +: FANIN]);
    end
  end

  // Reset mode is OR so that an uninverted zero reads out as QN=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= MODE_OR;
    end else if (adv) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= red;
        mode_q <= up_mode;
      end
    end
  end

endmodule

// File: rtl/nor_reduce_pipe.sv
// Pipelined NOR/OR/NAND/AND reduction of a WIDTH-bit vector, one register per tree level.
// Handshake: a beat transfers on a rising edge where valid & ready are both high; ready never waits on valid.
module nor_reduce_pipe
  import nor_reduce_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FANIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             qn,
  output logic             busy
);

  localparam int LEVELS = clog_fanin(WIDTH, FANIN);
  localparam int BUS_W  = level_offset(WIDTH, FANIN, LEVELS + 1);

  // Segment k of dbus carries the vector entering level k; vbus/mbus index the same way.
  logic [BUS_W-1:0]      dbus;
  logic [LEVELS:0]       vbus;
  logic [2*LEVELS+1:0]   mbus;
  logic [LEVELS-1:0]     adv;
  logic                  chain;

  assign dbus[WIDTH-1:0] = in;
  assign vbus[0]         = in_valid;
  assign mbus[1:0]       = mode;

  // Ready ripples back from the output: a stage may load if it is empty or its successor moves.
  always_comb begin
    adv   = '0;
    chain = out_ready;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      chain  = ~vbus[k+1] | chain;
      adv[k] = chain;
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int IW = level_width(WIDTH, FANIN, k);
    localparam int OW = level_width(WIDTH, FANIN, k + 1);
    localparam int IO = level_offset(WIDTH, FANIN, k);
    localparam int OO = level_offset(WIDTH, FANIN, k + 1);

    reduce_stage #(.IN_W(IW), .FANIN(FANIN)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv[k]),
      .up_valid (vbus[k]),
      .up_mode  (mbus[2*k +: 2]),
      .up_data  (dbus[IO +: IW]),
      .valid_q  (vbus[k+1]),
      .mode_q   (mbus[2*(k+1) +: 2]),
      .data_q   (dbus[OO +: OW])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = vbus[LEVELS];
  assign qn        = dbus[BUS_W-1] ^ invert_result(mbus[2*LEVELS +: 2]);
  assign busy      = |vbus[LEVELS:1];

endmodule
